// File: rtl/des32b_pkg.sv
// Shared types and widths for the 1:32 aligning deserializer.
package des32b_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 5;
  localparam int ERR_W  = 16;

  localparam logic [WORD_W-1:0] ALIGN_WORD_DEFAULT = 32'h0F2D_A5C3;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/des32b_align_fsm.sv
// Word-alignment state machine: decides on each word boundary whether to
// bit-slip, advance toward lock, or drop lock. Holds the match/miss counters.
module des32b_align_fsm
  import des32b_pkg::*;
#(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 4
) (
  input  logic CLKBit,
  input  logic RSTn,
  input  logic i_boundary,
  input  logic i_match,
  input  logic i_align_en,
  output logic o_slip,
  output logic o_locked
);

  localparam logic [3:0] LOCK_C   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_COUNT);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_mcnt;
  logic [3:0] w_mcnt_next;
  logic [3:0] r_ucnt;
  logic [3:0] w_ucnt_next;
  logic [3:0] w_mcnt_inc;
  logic [3:0] w_ucnt_inc;

  assign w_mcnt_inc = r_mcnt + 4'd1;
  assign w_ucnt_inc = r_ucnt + 4'd1;

  // State and counter registers
  always_ff @(posedge CLKBit or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= SEARCH;
      r_mcnt  <= '0;
      r_ucnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_mcnt  <= w_mcnt_next;
      r_ucnt  <= w_ucnt_next;
    end
  end

  // Next-state decision, evaluated only on word boundaries
  always_comb begin
    w_state_next = r_state;
    w_mcnt_next  = r_mcnt;
    w_ucnt_next  = r_ucnt;
    o_slip       = 1'b0;
    if (i_boundary) begin
      case (r_state)
        SEARCH, CHECK: begin
          if (i_align_en) begin
            if (i_match) begin
              // SEARCH has mcnt=0, so the same increment covers the first match
              if (w_mcnt_inc == LOCK_C) begin
                w_state_next = LOCKED;
                w_mcnt_next  = '0;
                w_ucnt_next  = '0;
              end else begin
                w_state_next = CHECK;
                w_mcnt_next  = w_mcnt_inc;
              end
            end else begin
              w_state_next = SEARCH;
              w_mcnt_next  = '0;
              o_slip       = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (!i_align_en || i_match) begin
            w_ucnt_next = '0;
          end else if (w_ucnt_inc == UNLOCK_C) begin
            // Lock lost: restart the search without slipping on this boundary
            w_state_next = SEARCH;
            w_ucnt_next  = '0;
            w_mcnt_next  = '0;
          end else begin
            w_ucnt_next = w_ucnt_inc;
          end
        end
        default: begin
          w_state_next = SEARCH;
          w_mcnt_next  = '0;
          w_ucnt_next  = '0;
        end
      endcase
    end
  end

  assign o_locked = (r_state == LOCKED);

endmodule

// File: rtl/des32b_align.sv
// 1:32 MSB-first deserializer with training-word alignment by bit slipping.
// Optional feature: define DES32B_ERRCNT_EN to enable the locked-mode
// mismatch counter on ErrCnt; otherwise ErrCnt is constant zero.
module des32b_align
  import des32b_pkg::*;
#(
  parameter logic [31:0] ALIGN_WORD   = ALIGN_WORD_DEFAULT,
  parameter int          LOCK_COUNT   = 4,
  parameter int          UNLOCK_COUNT = 4
) (
  input  logic        CLKBit,
  input  logic        RSTn,
  input  logic        DataIn,
  input  logic        AlignEn,
  output logic [31:0] DataOut,
  output logic        DataValid,
  output logic        CLKWord,
  output logic        Locked,
  output logic [4:0]  SlipCount,
  output logic [15:0] ErrCnt
);

  // Only 31 bits are stored; the 32nd bit of a word is the live DataIn.
  logic [WORD_W-2:0] r_sh;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_slip_hold;
  logic [WORD_W-1:0] r_data_out;
  logic              r_data_valid;
  logic [CNT_W-1:0]  r_slip_cnt;
  logic [WORD_W-1:0] w_word;
  logic              w_boundary;
  logic              w_match;
  logic              w_slip;
  logic              w_locked;

  assign w_word     = {r_sh, DataIn};
  assign w_boundary = (r_cnt == '0);
  assign w_match    = (w_word == ALIGN_WORD);

  des32b_align_fsm #(
    .LOCK_COUNT  (LOCK_COUNT),
    .UNLOCK_COUNT(UNLOCK_COUNT)
  ) u_fsm (
    .CLKBit    (CLKBit),
    .RSTn      (RSTn),
    .i_boundary(w_boundary),
    .i_match   (w_match),
    .i_align_en(AlignEn),
    .o_slip    (w_slip),
    .o_locked  (w_locked)
  );

  // Shift register and down-counting bit counter; a slip freezes the counter
  // for the cycle after the boundary so the next boundary lands one bit later.
  always_ff @(posedge CLKBit or negedge RSTn) begin
    if (!RSTn) begin
      r_sh        <= '0;
      r_cnt       <= '1;
      r_slip_hold <= 1'b0;
    end else begin
      r_sh        <= w_word[WORD_W-2:0];
      r_slip_hold <= w_slip;
      if (!r_slip_hold) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // Word output register with one-cycle valid pulse at each boundary
  always_ff @(posedge CLKBit or negedge RSTn) begin
    if (!RSTn) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= w_boundary;
      if (w_boundary) begin
        r_data_out <= w_word;
      end
    end
  end

  // Running count of applied slips, wrapping modulo 32
  always_ff @(posedge CLKBit or negedge RSTn) begin
    if (!RSTn) begin
      r_slip_cnt <= '0;
    end else if (w_slip) begin
      r_slip_cnt <= r_slip_cnt + CNT_W'(1);
    end
  end

`ifdef DES32B_ERRCNT_EN
  logic [ERR_W-1:0] r_err_cnt;

  // Saturating count of bad words seen while locked with training enabled
  always_ff @(posedge CLKBit or negedge RSTn) begin
    if (!RSTn) begin
      r_err_cnt <= '0;
    end else if (w_boundary && AlignEn && w_locked && !w_match &&
                 (r_err_cnt != {ERR_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  assign ErrCnt = r_err_cnt;
`else
  assign ErrCnt = '0;
`endif

  assign DataOut   = r_data_out;
  assign DataValid = r_data_valid;
  assign CLKWord   = r_cnt[CNT_W-1];
  assign Locked    = w_locked;
  assign SlipCount = r_slip_cnt;

endmodule
